parity_pkt_buf: RTL

- Store-and-forward packet buffer placed directly downstream of the odd-parity generator stage.
- Accepts 9-bit words framed by sop/eop/vld, where bit[8] is the odd-parity bit.
- Checks parity on every word and holds each packet until its eop arrives.
- Forwards only error-free, well-framed packets to the consumer over a valid/ready interface. Corrupted, overflowing or mis-framed packets are dropped.

---
 rtl/parity_pkt_buf.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/parity_pkt_buf.sv
// parity_pkt_buf
//   Store-and-forward packet buffer sitting behind the odd-parity generator.
//   Incoming 9-bit words ({parity, payload}) framed by sop/eop/vld are
//   parity-checked and held in a circular buffer until the packet's eop
//   arrives. Only complete, error-free packets become visible to the read
//   side; corrupted, overflowing or mis-framed packets are rewound away.
//
//   Optional feature macro: PARITY_PKT_STAT_EN adds saturating good/drop
//   packet counters (good_cnt, drop_cnt).
//
// Ports
//   sys_clk, sys_rst          clock, synchronous active-high reset
//   in_sop/in_eop/in_vld      input framing, no backpressure
//   in_data[8:0]              [8] odd-parity bit, [7:0] payload
//   out_sop/out_eop/out_vld   forwarded packet framing
//   out_data[7:0]             payload with parity stripped
//   out_rdy                   consumer ready (transfer on out_vld & out_rdy)
//   par_err                   pulse per accepted word with even 9-bit parity
//   pkt_drop                  pulse per discarded packet
//   good_cnt, drop_cnt        (PARITY_PKT_STAT_EN only) packet statistics
module parity_pkt_buf #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       in_sop,
  input  logic       in_eop,
  input  logic       in_vld,
  input  logic [8:0] in_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_vld,
  output logic [7:0] out_data,
  input  logic       out_rdy,
  output logic       par_err,
  output logic       pkt_drop
`ifdef PARITY_PKT_STAT_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DISCARD} wr_state_t;

  logic [8:0]  mem [DEPTH];

  wr_state_t   state, state_nxt;
  logic [AW:0] wr_ptr, wr_ptr_nxt;
  logic [AW:0] cm_ptr, cm_ptr_nxt;
  logic [AW:0] rd_ptr;
  logic        err_flag, err_nxt;
  logic        commit;
  logic        wr_en;
  logic [AW-1:0] wr_addr;
  logic        par_err_nxt, drop_nxt;
  logic        bad;
  logic        full_wr, full_cm;
  logic        start;

  // Output register stage
  logic [7:0]  data_p1;
  logic        eop_p1, sop_p1, vld_p1;
  logic        sop_arm;
  logic [8:0]  rd_word;
  logic        avail, xfer, load;

  // ---------------- p0: parity check and write FSM ----------------
  assign bad     = ~(^in_data);
  // Occupancy counts uncommitted words too, and uses rd_ptr before this
  // cycle's read.
  assign full_wr = (wr_ptr - rd_ptr) == FULL_CNT;
  assign full_cm = (cm_ptr - rd_ptr) == FULL_CNT;

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    cm_ptr_nxt  = cm_ptr;
    err_nxt     = err_flag;
    commit      = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = wr_ptr[AW-1:0];
    drop_nxt    = 1'b0;
    start       = 1'b0;
    // Words ignored in IDLE (no sop) are not accepted, so no parity pulse.
    par_err_nxt = in_vld && bad && (state != IDLE || in_sop);

    if (in_vld) begin
      case (state)
        IDLE: begin
          if (in_sop) start = 1'b1;
        end
        RECV: begin
          if (in_sop) begin
            // Open packet abandoned: discard it and restart from this word.
            wr_ptr_nxt = cm_ptr;
            drop_nxt   = 1'b1;
            start      = 1'b1;
          end else if (full_wr) begin
            wr_ptr_nxt = cm_ptr;
            if (in_eop) begin
              drop_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = DISCARD;
            end
          end else begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            err_nxt    = err_flag | bad;
            if (in_eop) begin
              state_nxt = IDLE;
              if (!err_flag && !bad) begin
                cm_ptr_nxt = wr_ptr + 1'b1;
                commit     = 1'b1;
              end else begin
                wr_ptr_nxt = cm_ptr;
                drop_nxt   = 1'b1;
              end
            end
          end
        end
        DISCARD: begin
          if (in_sop) begin
            drop_nxt = 1'b1;
            start    = 1'b1;
          end else if (in_eop) begin
            drop_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase

      // A new packet always begins at the committed boundary; in IDLE and
      // DISCARD wr_ptr already equals cm_ptr.
      if (start) begin
        if (full_cm) begin
          wr_ptr_nxt = cm_ptr;
          if (in_eop) begin
            drop_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DISCARD;
          end
        end else begin
          wr_en      = 1'b1;
          wr_addr    = cm_ptr[AW-1:0];
          wr_ptr_nxt = cm_ptr + 1'b1;
          err_nxt    = bad;
          if (in_eop) begin
            state_nxt = IDLE;
            if (!bad) begin
              cm_ptr_nxt = cm_ptr + 1'b1;
              commit     = 1'b1;
            end else begin
              wr_ptr_nxt = cm_ptr;
              drop_nxt   = 1'b1;
            end
          end else begin
            state_nxt = RECV;
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      err_flag <= 1'b0;
      par_err  <= 1'b0;
      pkt_drop <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      if (commit) cm_ptr <= cm_ptr_nxt;
      err_flag <= err_nxt;
      par_err  <= par_err_nxt;
      pkt_drop <= drop_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= {in_eop, in_data[7:0]};
  end

  // ---------------- p1: first-word-fall-through output register ----------------
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign avail   = cm_ptr != rd_ptr;
  assign xfer    = vld_p1 && out_rdy;
  assign load    = avail && (!vld_p1 || out_rdy);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_ptr  <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      eop_p1  <= 1'b0;
      sop_p1  <= 1'b0;
      sop_arm <= 1'b1;
    end else begin
      if (load) begin
        data_p1 <= rd_word[7:0];
        eop_p1  <= rd_word[8];
        // When the previous word leaves this same cycle, its eop decides sop.
        sop_p1  <= xfer ? eop_p1 : sop_arm;
        vld_p1  <= 1'b1;
        rd_ptr  <= rd_ptr + 1'b1;
      end else if (xfer) begin
        vld_p1  <= 1'b0;
      end
      if (xfer) sop_arm <= eop_p1;
    end
  end

  assign out_vld  = vld_p1;
  assign out_data = data_p1;
  assign out_eop  = eop_p1;
  assign out_sop  = sop_p1;

`ifdef PARITY_PKT_STAT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      good_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (commit)   good_cnt <= sat_inc(good_cnt);
      if (drop_nxt) drop_cnt <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule
